memif_arb_prio: RTL and testbench

N-port priority arbiter sharing one memif command/data channel between several burst masters in front of `qpi_memctrl`. Requesters are split into high- and low-priority classes, with round-robin inside each class. An optional starvation guard bounds low-priority wait. A grant is held for one whole burst: command handshake plus all data beats. Typical use: HDMI scan-out reader high, SPI writer and other masters low.

---
 rtl/memif_arb_prio.sv | 199 +++++++++++++++++++
 tb/tb_memif_arb_prio.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memif_arb_prio.sv
`default_nettype none
// ============================================================================
// memif_arb_prio : two-class (high/low) round-robin arbiter sharing one memif
// command/data channel; a grant spans command handshake plus all data beats.
// Optional starvation guard on the low class: define MEMIF_ARB_STARVE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module memif_arb_prio #(
    parameter int             AW         = 23,
    parameter int             DW         = 16,
    parameter int             N          = 4,
    parameter logic [N-1:0]   HI_PRIO    = {{(N-1){1'b0}}, 1'b1},
    parameter int             STARVE_LIM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*AW-1:0]   d_addr,
    input  logic [N*7-1:0]    d_len,
    input  logic [N-1:0]      d_rw,
    input  logic [N-1:0]      d_valid,
    output logic [N-1:0]      d_ready,
    input  logic [N*DW-1:0]   d_wdata,
    output logic [N-1:0]      d_wack,
    output logic [N-1:0]      d_wlast,
    output logic [N*DW-1:0]   d_rdata,
    output logic [N-1:0]      d_rstb,
    output logic [N-1:0]      d_rlast,
    output logic [AW-1:0]     u_addr,
    output logic [6:0]        u_len,
    output logic              u_rw,
    output logic              u_valid,
    input  logic              u_ready,
    output logic [DW-1:0]     u_wdata,
    input  logic              u_wack,
    input  logic              u_wlast,
    input  logic [DW-1:0]     u_rdata,
    input  logic              u_rstb,
    input  logic              u_rlast
);

    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    generate
        if (N < 2 || N > 8 || STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_param_check
            $error("memif_arb_prio: parameter out of range");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   w_sel_nxt;
    logic [SW-1:0]   r_rr_hi;
    logic [SW-1:0]   r_rr_lo;
    logic            r_rw;
    logic [N-1:0]    w_hi_pend;
    logic [N-1:0]    w_lo_pend;
    logic [SW-1:0]   w_pick_hi;
    logic [SW-1:0]   w_pick_lo;
    logic [SW-1:0]   w_winner;
    logic            w_override;
    logic            w_done;

    // First requester strictly after 'last', wrapping N-1 -> 0.
    function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [SW-1:0] last);
        logic [SW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx[SW-1:0]]) begin
                pick  = idx[SW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_hi_pend = d_valid & HI_PRIO;
        w_lo_pend = d_valid & ~HI_PRIO;
        w_pick_hi = rr_pick(w_hi_pend, r_rr_hi);
        w_pick_lo = rr_pick(w_lo_pend, r_rr_lo);
        w_winner  = (|w_hi_pend && !w_override) ? w_pick_hi : w_pick_lo;
    end

`ifdef MEMIF_ARB_STARVE_EN
    localparam logic [7:0] c_starve_lim = 8'(STARVE_LIM);

    logic [7:0] r_starve_cnt;
    logic       w_winner_hi;

    assign w_override  = (r_starve_cnt >= c_starve_lim) && (|w_lo_pend);
    assign w_winner_hi = HI_PRIO[w_winner];

    // Counted at winner selection; any pending low request means a grant happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 8'd0;
        end else if (r_state == S_IDLE) begin
            if (!(|w_lo_pend) || !w_winner_hi) begin
                r_starve_cnt <= 8'd0;
            end else if (r_starve_cnt != 8'hFF) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end
`else
    assign w_override = 1'b0;
`endif

    assign w_done = (r_state == S_DATA) &&
                    (r_rw ? (u_rstb && u_rlast) : (u_wack && u_wlast));

    // A handshake wins over a same-cycle d_valid drop: the controller took it.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            S_IDLE: begin
                if (|d_valid) begin
                    w_sel_nxt   = w_winner;
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (u_ready) begin
                    w_state_nxt = S_DATA;
                end else if (!d_valid[r_sel]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_rr_hi <= SW'(N - 1);
            r_rr_lo <= SW'(N - 1);
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            if (r_state == S_CMD && u_ready) begin
                r_rw <= u_rw;
                if (HI_PRIO[r_sel]) begin
                    r_rr_hi <= r_sel;
                end else begin
                    r_rr_lo <= r_sel;
                end
            end
        end
    end

    always_comb begin
        u_addr  = d_addr[int'(r_sel) * AW +: AW];
        u_len   = d_len[int'(r_sel) * 7 +: 7];
        u_rw    = d_rw[r_sel];
        u_wdata = d_wdata[int'(r_sel) * DW +: DW];
        u_valid = (r_state == S_CMD);
        d_rdata = {N{u_rdata}};
        d_ready = '0;
        d_wack  = '0;
        d_wlast = '0;
        d_rstb  = '0;
        d_rlast = '0;
        if (r_state == S_CMD) begin
            d_ready[r_sel] = u_ready;
        end
        if (r_state == S_DATA) begin
            if (r_rw) begin
                d_rstb[r_sel]  = u_rstb;
                d_rlast[r_sel] = u_rlast;
            end else begin
                d_wack[r_sel]  = u_wack;
                d_wlast[r_sel] = u_wlast;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memif_arb_prio.sv
`default_nettype none
// ============================================================================
// tb_memif_arb_prio : randomized self-checking bench for memif_arb_prio with a
// class/round-robin/starvation reference model and a simple controller model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memif_arb_prio;

    localparam int         AW  = 23;
    localparam int         DW  = 16;
    localparam int         N   = 4;
    localparam int         LIM = 4;
    localparam logic [3:0] HI  = 4'b0001;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   d_addr;
    logic [N*7-1:0]    d_len;
    logic [N-1:0]      d_rw;
    logic [N-1:0]      d_valid;
    logic [N-1:0]      d_ready;
    logic [N*DW-1:0]   d_wdata;
    logic [N-1:0]      d_wack;
    logic [N-1:0]      d_wlast;
    logic [N*DW-1:0]   d_rdata;
    logic [N-1:0]      d_rstb;
    logic [N-1:0]      d_rlast;
    logic [AW-1:0]     u_addr;
    logic [6:0]        u_len;
    logic              u_rw;
    logic              u_valid;
    logic              u_ready;
    logic [DW-1:0]     u_wdata;
    logic              u_wack;
    logic              u_wlast;
    logic [DW-1:0]     u_rdata;
    logic              u_rstb;
    logic              u_rlast;

    int         vectors = 0;
    int         errors  = 0;
    int         m_rr_hi;
    int         m_rr_lo;
    int         m_starve;
    logic [3:0] hi_mask = HI;

    always #5 clk = ~clk;

    memif_arb_prio #(
        .AW(AW), .DW(DW), .N(N), .HI_PRIO(HI), .STARVE_LIM(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .d_addr(d_addr), .d_len(d_len), .d_rw(d_rw), .d_valid(d_valid),
        .d_ready(d_ready), .d_wdata(d_wdata), .d_wack(d_wack), .d_wlast(d_wlast),
        .d_rdata(d_rdata), .d_rstb(d_rstb), .d_rlast(d_rlast),
        .u_addr(u_addr), .u_len(u_len), .u_rw(u_rw), .u_valid(u_valid),
        .u_ready(u_ready), .u_wdata(u_wdata), .u_wack(u_wack), .u_wlast(u_wlast),
        .u_rdata(u_rdata), .u_rstb(u_rstb), .u_rlast(u_rlast)
    );

    // Reference model: class choice, round-robin within class, starvation guard.
    function automatic int pick_after(input logic [3:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int model_grant(input logic [3:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        bit         ovr;
        int         w;
        hi  = v & hi_mask;
        lo  = v & ~hi_mask;
        ovr = 1'b0;
`ifdef MEMIF_ARB_STARVE_EN
        ovr = (m_starve >= LIM) && (lo != 4'b0);
`endif
        if (hi != 4'b0 && !ovr) w = pick_after(hi, m_rr_hi);
        else                    w = pick_after(lo, m_rr_lo);
`ifdef MEMIF_ARB_STARVE_EN
        if (lo == 4'b0 || !hi[w]) m_starve = 0;
        else if (m_starve < 255)  m_starve = m_starve + 1;
`endif
        return w;
    endfunction

    function automatic void model_commit(input int w);
        if (hi_mask[w]) m_rr_hi = w;
        else            m_rr_lo = w;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_strobes();
        u_wack  = 1'b0;
        u_wlast = 1'b0;
        u_rstb  = 1'b0;
        u_rlast = 1'b0;
    endtask

    task automatic rand_fields(input int maxlen);
        for (int i = 0; i < N; i++) begin
            d_addr[i*AW +: AW]  = AW'($urandom);
            d_len[i*7 +: 7]     = 7'($urandom_range(0, maxlen));
            d_rw[i]             = 1'($urandom_range(0, 1));
            d_wdata[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        d_valid = '0;
        u_ready = 1'b0;
        u_rdata = '0;
        clear_strobes();
        rst = 1'b1;
        step();
        step();
        rst      = 1'b0;
        m_rr_hi  = N - 1;
        m_rr_lo  = N - 1;
        m_starve = 0;
    endtask

    // Controller model: waits for a command, accepts it, plays all data beats.
    task automatic serve(input int delay, output int lane, output int waited,
                         output logic [AW-1:0] addr, output logic rw_seen,
                         output logic [N-1:0] stb_mask, output logic [N-1:0] last_mask);
        int len;
        lane = -1; waited = 0; addr = '0; rw_seen = 1'b0;
        stb_mask = '0; last_mask = '0;
        while (u_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (u_valid !== 1'b1) return;
        repeat (delay) step();
        u_ready = 1'b1;
        #1;
        for (int i = 0; i < N; i++) if (d_ready === 4'(1 << i)) lane = i;
        addr    = u_addr;
        len     = int'(u_len);
        rw_seen = u_rw;
        step();
        u_ready = 1'b0;
        for (int b = 0; b <= len; b++) begin
            u_rdata = DW'($urandom);
            if (rw_seen) begin u_rstb = 1'b1; u_rlast = (b == len); end
            else         begin u_wack = 1'b1; u_wlast = (b == len); end
            #1;
            stb_mask = stb_mask | d_rstb | d_wack;
            if (b == len) last_mask = d_rlast | d_wlast;
            step();
            clear_strobes();
        end
    endtask

    task automatic test_reset();
        rand_fields(7);
        rst = 1'b1; d_valid = '0; u_ready = 1'b1;
        u_rstb = 1'b1; u_rlast = 1'b1; u_wack = 1'b1; u_wlast = 1'b1;
        #1;
        vectors++; if (u_valid !== 1'b0) begin errors++; $display("FAIL reset_u_valid: got %b want 0", u_valid); end
        vectors++; if ((d_ready | d_rstb | d_rlast | d_wack | d_wlast) !== 4'b0) begin errors++;
            $display("FAIL reset_strobes: got rdy=%b rstb=%b rlast=%b wack=%b wlast=%b want 0", d_ready, d_rstb, d_rlast, d_wack, d_wlast); end
        vectors++; if (u_addr !== d_addr[AW-1:0] || u_len !== d_len[6:0] || u_rw !== d_rw[0]) begin errors++;
            $display("FAIL reset_cmd_mux: got %h/%h/%b want %h/%h/%b", u_addr, u_len, u_rw, d_addr[AW-1:0], d_len[6:0], d_rw[0]); end
        vectors++; if (u_wdata !== d_wdata[DW-1:0]) begin errors++; $display("FAIL reset_wdata: got %h want %h", u_wdata, d_wdata[DW-1:0]); end
        step();
        rst = 1'b0;
        step();
        #1;
        vectors++; if ((d_rstb | d_wack | d_ready) !== 4'b0 || u_valid !== 1'b0) begin errors++;
            $display("FAIL idle_strobes_dropped: got rstb=%b wack=%b rdy=%b uv=%b want 0", d_rstb, d_wack, d_ready, u_valid); end
        clear_strobes();
        u_ready = 1'b0;
    endtask

    task automatic test_single_read();
        int w;
        do_reset();
        rand_fields(7);
        d_len[2*7 +: 7] = 7'd3;
        d_rw[2]  = 1'b1;
        u_ready  = 1'b1;
        d_valid  = 4'b0100;
        #1;
        vectors++; if (u_valid !== 1'b0) begin errors++; $display("FAIL rd_latency0: got %b want 0", u_valid); end
        w = model_grant(d_valid);
        step();
        vectors++; if (u_valid !== 1'b1 || d_ready !== 4'(1 << w)) begin errors++;
            $display("FAIL rd_cmd: got uv=%b rdy=%b want 1/%b", u_valid, d_ready, 4'(1 << w)); end
        vectors++; if (u_addr !== d_addr[w*AW +: AW] || u_len !== 7'd3 || u_rw !== 1'b1) begin errors++;
            $display("FAIL rd_cmd_fields: got %h/%0d/%b want %h/3/1", u_addr, u_len, u_rw, d_addr[w*AW +: AW]); end
        model_commit(w);
        step();
        d_valid = '0;
        u_ready = 1'b0;
        #1;
        vectors++; if (u_valid !== 1'b0 || d_ready !== 4'b0) begin errors++;
            $display("FAIL rd_data_cmd_idle: got uv=%b rdy=%b want 0/0", u_valid, d_ready); end
        for (int b = 0; b < 4; b++) begin
            u_rstb = 1'b1; u_rlast = (b == 3); u_wack = 1'b1; u_rdata = DW'($urandom);
            #1;
            vectors++; if (d_rstb !== 4'b0100 || d_rlast !== ((b == 3) ? 4'b0100 : 4'b0000) || d_wack !== 4'b0) begin errors++;
                $display("FAIL rd_beat%0d: got rstb=%b rlast=%b wack=%b", b, d_rstb, d_rlast, d_wack); end
            vectors++; if (d_rdata !== {N{u_rdata}}) begin errors++; $display("FAIL rd_rdata%0d: got %h want %h", b, d_rdata, {N{u_rdata}}); end
            step();
            clear_strobes();
        end
        u_rstb = 1'b1; u_rlast = 1'b1;
        #1;
        vectors++; if (d_rstb !== 4'b0 || u_valid !== 1'b0) begin errors++;
            $display("FAIL rd_back_idle: got rstb=%b uv=%b want 0/0", d_rstb, u_valid); end
        clear_strobes();
    endtask

    task automatic test_write();
        int w;
        do_reset();
        rand_fields(7);
        d_len[1*7 +: 7] = 7'd1;
        d_rw[1] = 1'b0;
        u_ready = 1'b1;
        d_valid = 4'b0010;
        w = model_grant(d_valid);
        step();
        d_wdata[DW +: DW] = DW'($urandom);
        #1;
        vectors++; if (u_valid !== 1'b1 || d_ready !== 4'(1 << w) || u_rw !== 1'b0) begin errors++;
            $display("FAIL wr_cmd: got uv=%b rdy=%b rw=%b", u_valid, d_ready, u_rw); end
        vectors++; if (u_wdata !== d_wdata[DW +: DW]) begin errors++; $display("FAIL wr_wdata_cmd: got %h want %h", u_wdata, d_wdata[DW +: DW]); end
        model_commit(w);
        step();
        d_valid = '0;
        u_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            d_wdata[DW +: DW] = DW'($urandom);
            u_wack = 1'b1; u_wlast = (b == 1); u_rstb = 1'b1;
            #1;
            vectors++; if (u_wdata !== d_wdata[DW +: DW]) begin errors++; $display("FAIL wr_wdata%0d: got %h want %h", b, u_wdata, d_wdata[DW +: DW]); end
            vectors++; if (d_wack !== 4'b0010 || d_wlast !== ((b == 1) ? 4'b0010 : 4'b0000) || d_rstb !== 4'b0) begin errors++;
                $display("FAIL wr_beat%0d: got wack=%b wlast=%b rstb=%b", b, d_wack, d_wlast, d_rstb); end
            step();
            clear_strobes();
        end
        #1;
        vectors++; if (u_valid !== 1'b0 || d_wack !== 4'b0) begin errors++; $display("FAIL wr_done: got uv=%b wack=%b want 0", u_valid, d_wack); end
    endtask

    task automatic test_back_to_back();
        int w, lane, waited;
        logic [AW-1:0] addr;
        logic rw;
        logic [N-1:0] sm, lm;
        do_reset();
        rand_fields(2);
        d_valid = 4'b1110;
        for (int k = 0; k < 6; k++) begin
            w = model_grant(d_valid);
            serve(0, lane, waited, addr, rw, sm, lm);
            vectors++; if (lane !== w) begin errors++; $display("FAIL lo_rr_grant%0d: got %0d want %0d", k, lane, w); end
            vectors++; if (waited !== 1) begin errors++; $display("FAIL b2b_latency%0d: got %0d cycles want 1", k, waited); end
            model_commit(w);
        end
    endtask

    task automatic test_starve();
        int w, lane, waited;
        logic [AW-1:0] addr;
        logic rw;
        logic [N-1:0] sm, lm;
        do_reset();
        rand_fields(1);
        d_valid = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            w = model_grant(d_valid);
            serve(0, lane, waited, addr, rw, sm, lm);
            vectors++; if (lane !== w) begin errors++; $display("FAIL starve_grant%0d: got %0d want %0d", k, lane, w); end
            model_commit(w);
        end
    endtask

    task automatic test_drop();
        int w, lane, waited;
        logic [AW-1:0] addr;
        logic rw;
        logic [N-1:0] sm, lm;
        do_reset();
        rand_fields(2);
        d_valid = 4'b0100;
        w = model_grant(d_valid);
        step();
        vectors++; if (u_valid !== 1'b1) begin errors++; $display("FAIL drop_cmd: got %b want 1", u_valid); end
        d_valid = 4'b1010;
        #1;
        vectors++; if (u_valid !== 1'b1 || d_ready !== 4'b0) begin errors++; $display("FAIL drop_same_cycle: got uv=%b rdy=%b want 1/0", u_valid, d_ready); end
        step();
        vectors++; if (u_valid !== 1'b0) begin errors++; $display("FAIL drop_u_valid_fall: got %b want 0", u_valid); end
        w = model_grant(d_valid);
        serve(0, lane, waited, addr, rw, sm, lm);
        vectors++; if (lane !== w || addr !== d_addr[w*AW +: AW]) begin errors++;
            $display("FAIL drop_regrant: got %0d/%h want %0d/%h", lane, addr, w, d_addr[w*AW +: AW]); end
        model_commit(w);
    endtask

    task automatic test_async_reset();
        do_reset();
        rand_fields(1);
        d_len[2*7 +: 7] = 7'd5;
        d_rw[2]  = 1'b1;
        u_ready  = 1'b1;
        d_valid  = 4'b0100;
        step();
        step();
        d_valid = '0;
        u_ready = 1'b0;
        u_rstb  = 1'b1;
        #1;
        vectors++; if (d_rstb !== 4'b0100) begin errors++; $display("FAIL arst_pre: got rstb=%b want 0100", d_rstb); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (d_rstb !== 4'b0 || u_valid !== 1'b0 || d_ready !== 4'b0) begin errors++;
            $display("FAIL arst_immediate: got rstb=%b uv=%b rdy=%b want 0", d_rstb, u_valid, d_ready); end
        #2;
        rst = 1'b0;
        clear_strobes();
        m_rr_hi = N - 1; m_rr_lo = N - 1; m_starve = 0;
        step();
        vectors++; if (u_valid !== 1'b0) begin errors++; $display("FAIL arst_idle: got %b want 0", u_valid); end
        d_valid = 4'b0010;
        step();
        vectors++; if (u_valid !== 1'b1 || u_addr !== d_addr[AW +: AW]) begin errors++;
            $display("FAIL arst_rearb: got uv=%b addr=%h want 1/%h", u_valid, u_addr, d_addr[AW +: AW]); end
    endtask

    task automatic test_random();
        int w, lane, waited;
        logic [AW-1:0] addr;
        logic rw;
        logic [N-1:0] sm, lm;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            rand_fields(3);
            d_valid = 4'($urandom_range(1, 15));
            w = model_grant(d_valid);
            serve($urandom_range(0, 2), lane, waited, addr, rw, sm, lm);
            vectors++; if (lane !== w) begin errors++; $display("FAIL rnd_grant%0d: mask=%b got %0d want %0d", k, d_valid, lane, w); end
            vectors++; if (addr !== d_addr[w*AW +: AW] || rw !== d_rw[w]) begin errors++;
                $display("FAIL rnd_cmd%0d: got %h/%b want %h/%b", k, addr, rw, d_addr[w*AW +: AW], d_rw[w]); end
            vectors++; if (sm !== 4'(1 << w) || lm !== 4'(1 << w)) begin errors++;
                $display("FAIL rnd_lanes%0d: got stb=%b last=%b want %b", k, sm, lm, 4'(1 << w)); end
            model_commit(w);
        end
        d_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_back_to_back();
        test_starve();
        test_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
